// File: rtl/win_checker.sv
`default_nettype none
// ============================================================================
// Module      : win_checker
// Description : Snapshots the board on a start continuation, scans every
//               five-in-a-row candidate (E, S, SE, SW) in row-major order,
//               marks the first winning line with the WIN code and hands the
//               marked board plus the winner to the painter stage.
// Revision    : 1.0 - initial release
// ============================================================================
module win_checker #(
    parameter int BOARD_WIDTH  = 10,
    parameter int BOARD_HEIGHT = 10,
    parameter int X_BITS       = 4,
    parameter int Y_BITS       = 4,
    parameter int CHESS_BITS   = 2,
    parameter int WIN_LEN      = 5
) (
    input  logic                                          Clck,
    input  logic                                          Reset,
    input  logic                                          in_cont_signal,
    output logic                                          out_cont_signal,
    input  logic                                          next_out_cont_signal,
    input  logic [BOARD_WIDTH*BOARD_HEIGHT*CHESS_BITS-1:0] board_in,
    output logic [BOARD_WIDTH*BOARD_HEIGHT*CHESS_BITS-1:0] board_out,
    output logic [1:0]                                    winning_information
);

    localparam int N_CELLS = BOARD_WIDTH * BOARD_HEIGHT;
    localparam int CELL_W  = $clog2(N_CELLS);
    localparam int MARK_W  = $clog2(WIN_LEN);

    localparam logic [CHESS_BITS-1:0] c_CELL_BLACK = CHESS_BITS'(1);
    localparam logic [CHESS_BITS-1:0] c_CELL_BLUE  = CHESS_BITS'(2);
    localparam logic [CHESS_BITS-1:0] c_CELL_WIN   = CHESS_BITS'(3);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_SCAN = 2'd1,
        S_MARK = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t                r_state;
    logic [X_BITS-1:0]     r_x;
    logic [Y_BITS-1:0]     r_y;
    logic [1:0]            r_d;
    logic [MARK_W-1:0]     r_mark;

    logic [CHESS_BITS-1:0] w_cells [N_CELLS];
    logic [CELL_W-1:0]     w_idx   [WIN_LEN];
    logic                  w_in_bounds;
    logic                  w_hit;
    logic                  w_last;
    logic [CHESS_BITS-1:0] w_first;

    // The scan reads the snapshot held in board_out; unpack it into cells.
    genvar gi;
    generate
        for (gi = 0; gi < N_CELLS; gi++) begin : g_unpack
            assign w_cells[gi] = board_out[gi*CHESS_BITS +: CHESS_BITS];
        end
    endgenerate

    // Bounds test and cell indices of the current candidate line; an
    // out-of-bounds candidate is pinned to cell 0 so no index leaves the board.
    always_comb begin
        int w_cx;
        int w_cy;
        w_cx        = 0;
        w_cy        = 0;
        w_in_bounds = 1'b0;
        case (r_d)
            2'd0:    w_in_bounds = (int'(r_x) <= BOARD_WIDTH - WIN_LEN);
            2'd1:    w_in_bounds = (int'(r_y) <= BOARD_HEIGHT - WIN_LEN);
            2'd2:    w_in_bounds = (int'(r_x) <= BOARD_WIDTH - WIN_LEN) &&
                                   (int'(r_y) <= BOARD_HEIGHT - WIN_LEN);
            default: w_in_bounds = (int'(r_x) >= WIN_LEN - 1) &&
                                   (int'(r_y) <= BOARD_HEIGHT - WIN_LEN);
        endcase
        for (int i = 0; i < WIN_LEN; i++) begin
            case (r_d)
                2'd0: begin
                    w_cx = int'(r_x) + i;
                    w_cy = int'(r_y);
                end
                2'd1: begin
                    w_cx = int'(r_x);
                    w_cy = int'(r_y) + i;
                end
                2'd2: begin
                    w_cx = int'(r_x) + i;
                    w_cy = int'(r_y) + i;
                end
                default: begin
                    w_cx = int'(r_x) - i;
                    w_cy = int'(r_y) + i;
                end
            endcase
            if (!w_in_bounds) begin
                w_cx = 0;
                w_cy = 0;
            end
            w_idx[i] = CELL_W'(w_cy * BOARD_WIDTH + w_cx);
        end
    end

    // A hit needs five identical BLACK or BLUE cells; NONE and WIN never win.
    always_comb begin
        w_first = w_cells[w_idx[0]];
        w_hit   = w_in_bounds && ((w_first == c_CELL_BLACK) || (w_first == c_CELL_BLUE));
        for (int i = 1; i < WIN_LEN; i++) begin
            if (w_cells[w_idx[i]] != w_first) begin
                w_hit = 1'b0;
            end
        end
        w_last = (r_x == X_BITS'(BOARD_WIDTH - 1)) &&
                 (r_y == Y_BITS'(BOARD_HEIGHT - 1)) &&
                 (r_d == 2'd3);
    end

    // Control FSM: snapshot, scan, mark, then raise done until released.
    always_ff @(posedge Clck) begin
        if (!Reset) begin
            r_state             <= S_IDLE;
            out_cont_signal     <= 1'b0;
            winning_information <= 2'b00;
            board_out           <= '0;
            r_x                 <= '0;
            r_y                 <= '0;
            r_d                 <= '0;
            r_mark              <= '0;
        end else if (out_cont_signal && next_out_cont_signal) begin
            out_cont_signal <= 1'b0;
        end else if (in_cont_signal && !out_cont_signal) begin
            case (r_state)
                S_IDLE: begin
                    board_out           <= board_in;
                    winning_information <= 2'b00;
                    r_x                 <= '0;
                    r_y                 <= '0;
                    r_d                 <= '0;
                    r_mark              <= '0;
                    r_state             <= S_SCAN;
                end
                S_SCAN: begin
                    if (w_hit) begin
                        // Counters stay put so they hold the winning start cell.
                        winning_information <= (w_first == c_CELL_BLACK) ? 2'b01 : 2'b10;
                        r_mark              <= '0;
                        r_state             <= S_MARK;
                    end else if (w_last) begin
                        r_state <= S_DONE;
                    end else if (r_d == 2'd3) begin
                        r_d <= 2'd0;
                        if (r_x == X_BITS'(BOARD_WIDTH - 1)) begin
                            r_x <= '0;
                            r_y <= r_y + Y_BITS'(1);
                        end else begin
                            r_x <= r_x + X_BITS'(1);
                        end
                    end else begin
                        r_d <= r_d + 2'd1;
                    end
                end
                S_MARK: begin
                    for (int c = 0; c < N_CELLS; c++) begin
                        if (CELL_W'(c) == w_idx[r_mark]) begin
                            board_out[c*CHESS_BITS +: CHESS_BITS] <= c_CELL_WIN;
                        end
                    end
                    if (r_mark == MARK_W'(WIN_LEN - 1)) begin
                        r_state <= S_DONE;
                    end else begin
                        r_mark <= r_mark + MARK_W'(1);
                    end
                end
                default: begin
                    out_cont_signal <= 1'b1;
                    r_state         <= S_IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: doc/win_checker.md
Name: win_checker

Overview:
- Game-logic stage that sits directly upstream of the board painter in the continuation chain.
- On a start continuation it snapshots the board and scans every five-in-a-row candidate, horizontal, vertical and both diagonals.
- On the first hit it rewrites the five winning cells to the WIN code and reports the winner.
- When done it hands the marked board and the winning status to the painter through the in/out/next continuation handshake.

Parameters:
- BOARD_WIDTH, 10, number of columns.
- BOARD_HEIGHT, 10, number of rows.
- X_BITS, 4, width of the column index.
- Y_BITS, 4, width of the row index.
- CHESS_BITS, 2, bits per cell.
- WIN_LEN, 5, run length that counts as a win.

Ports:
- Clck  input  1  clock; all state changes on the rising edge.
- Reset  input  1  reset; synchronous, active-low.
- in_cont_signal  input  1  start/enable from the previous stage.
- out_cont_signal  output  1  done; starts the painter.
- next_out_cont_signal  input  1  painter has finished; releases out_cont_signal.
- board_in  input  BOARD_WIDTH*BOARD_HEIGHT*CHESS_BITS  current board.
  - Cell (x,y) is at bits [(y*BOARD_WIDTH+x)*CHESS_BITS +: CHESS_BITS].
  - Codes: NONE=0, BLACK=1, BLUE=2, WIN=3.
- board_out  output  same width as board_in  snapshot with the winning cells set to WIN.
- winning_information  output  2  00 = no win, 01 = black wins, 10 = blue wins.

Behaviour:
- Reset (Reset==0 at an edge), applied regardless of the current state:
  - state=IDLE, out_cont_signal=0, winning_information=00, board_out=0, all counters=0.
  - A reset mid-operation aborts the scan immediately.
- Active condition: in_cont_signal==1 && out_cont_signal==0.
  - When the condition is false in SCAN or MARK, all state is frozen (pause). Resuming continues exactly where it stopped.
- Release: whenever out_cont_signal==1 and next_out_cont_signal==1 at an edge, out_cont_signal is cleared. No other action happens on that edge.
- State IDLE, on an active edge:
  - board_out <= board_in (snapshot); winning_information <= 00.
  - Candidate index k=0; go to SCAN.
  - board_in is not sampled again until the next IDLE start, so changes during a scan are ignored.
- State SCAN, one candidate per active edge:
  - Candidate order: k = (y*BOARD_WIDTH + x)*4 + d. Row-major, x is the inner loop, d is innermost.
  - Directions: d=0 E (+1,0), d=1 S (0,+1), d=2 SE (+1,+1), d=3 SW (-1,+1).
  - Bounds: E needs x<=W-5; S needs y<=H-5; SE needs both; SW needs x>=4 and y<=H-5.
  - An out-of-bounds candidate is a miss, still consumes one cycle, and never indexes outside the board.
  - Hit: all 5 cells equal and the code is BLACK or BLUE. Cells holding WIN or NONE never match.
  - On a hit: latch the start cell, d and the colour; set winning_information (BLACK->01, BLUE->10); go to MARK.
  - On a miss at k=4*W*H-1: go to DONE. Otherwise k++.
- State MARK: five active edges; edge i (i=0..4) writes WIN into board_out cell start+i*(dx,dy). Then go to DONE.
- State DONE, one active edge: out_cont_signal <= 1; state <= IDLE. The outputs hold until the next start.
- Latency, counted from the first active edge = edge 1:
  - Candidate k is evaluated at edge k+2.
  - No win: out_cont_signal rises after edge 4*W*H+2 (402 for 10x10).
  - Win at candidate k: out_cont_signal rises after edge k+8.
- Multiple winning lines: only the first in scan order is reported and marked.
- Restart: if in_cont_signal is still 1 after the release edge, a new scan starts on the following edge.

Test Plan:
1. Empty board, in_cont=1 held -> out_cont rises after edge 402; winning_information=00; board_out=0.
2. BLACK at (2..6,3) horizontal, hit at k=128 -> out_cont after edge 136; winning_information=01; board_out cells (2..6,3)=3; all other cells equal board_in.
3. BLUE at (4,0),(3,1),(2,2),(1,3),(0,4) SW diagonal, hit at k=19 -> out_cont after edge 27; winning_information=10; those 5 cells=3.
4. BLACK at (0..3,0) plus BLUE at (4,0), and BLACK at (6..9,9) (row edge, no wrap into the next row) -> no win; out_cont after edge 402; winning_information=00.
5. Handshake, using the case 2 board:
   - After out_cont=1, hold next_out=0 for 10 edges -> out_cont stays 1 and board_out is stable.
   - Pulse next_out=1 -> out_cont=0 after that edge.
   - With in_cont=1 a rescan starts on the next edge, and winning_information=00 after it.
6. Disruptions, using the case 2 board:
   - Drop in_cont for 20 edges at edge 50 -> out_cont after edge 156.
   - Separately, Reset=0 at edge 50 -> after that edge out_cont=0, winning_information=00, board_out=0, state IDLE.
